alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's single-width FSM ALU.
- Accepts signed operand pairs with an operation group and code over a valid/ready handshake.
- Computes through a 2-stage registered pipeline and delivers the result with status flags over a valid/ready handshake.
- Sits between the operand-issue logic and the result consumer. Full backpressure, hold/null operations, illegal-op detection, and saturating operation counters.

---
 rtl/alu_pipe.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined signed ALU with three op groups, HOLD/illegal ops and saturating counters.
// Latency: 2 cycles from input accept to out_valid; throughput of 1 beat/cycle.
// Backpressure: out_ready low stalls stage 2, then stage 1, then deasserts in_ready (no loss, no bubble).
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready            : operand beat handshake (operand1, operand2, op_group, op_code)
//   out_valid/out_ready          : result beat handshake (alu_result, ovf_flag, zero_flag, err_flag)
//   op_count, err_count          : delivered beats / delivered illegal beats, saturating
//
// Build option: define ALU_PIPE_SATURATE_EN to clamp arithmetic results to the
// DATA_WIDTH signed range (ovf_flag still reports the unclamped overflow).

module alu_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [1:0]            op_group,
  input  logic [2:0]            op_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   alu_result,
  output logic                  ovf_flag,
  output logic                  zero_flag,
  output logic                  err_flag,
  output logic [CNT_WIDTH-1:0]  op_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam int W = DATA_WIDTH;

  // Internal operation kinds after group/code decode.
  localparam logic [3:0] K_ADD  = 4'd0;
  localparam logic [3:0] K_SUB  = 4'd1;
  localparam logic [3:0] K_DEC  = 4'd2;
  localparam logic [3:0] K_INC2 = 4'd3;
  localparam logic [3:0] K_NEG  = 4'd4;
  localparam logic [3:0] K_XOR  = 4'd5;
  localparam logic [3:0] K_AND  = 4'd6;
  localparam logic [3:0] K_NAND = 4'd7;
  localparam logic [3:0] K_OR   = 4'd8;
  localparam logic [3:0] K_XNOR = 4'd9;
  localparam logic [3:0] K_HOLD = 4'd10;
  localparam logic [3:0] K_ILL  = 4'd11;

  // ---------------------------------------------------------------- state
  logic                 s1_valid_q, s1_valid_d;
  logic [W-1:0]         s1_op1_q, s1_op1_d;
  logic [W-1:0]         s1_op2_q, s1_op2_d;
  logic [1:0]           s1_grp_q, s1_grp_d;
  logic [2:0]           s1_code_q, s1_code_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [W:0]           s2_result_q, s2_result_d;
  logic                 s2_ovf_q, s2_ovf_d;
  logic                 s2_zero_q, s2_zero_d;
  logic                 s2_err_q, s2_err_d;

  logic [W:0]           last_result_q, last_result_d;
  logic [CNT_WIDTH-1:0] op_count_q, op_count_d;
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

  // ---------------------------------------------------------------- handshake
  logic s2_load;
  logic in_fire;
  logic out_fire;

  always_comb begin
    s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    // Held low during reset so nothing is accepted on the reset edge.
    in_ready = !rst && (!s1_valid_q || s2_load);
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;
  end

  // ---------------------------------------------------------------- decode
  logic [3:0] kind;

  always_comb begin
    kind = K_ILL;
    case (s1_grp_q)
      2'd0: begin
        case (s1_code_q)
          3'd0: kind = K_ADD;
          3'd1: kind = K_SUB;
          3'd2: kind = K_XOR;
          3'd3: kind = K_AND;
          3'd4: kind = K_NAND;
          3'd5: kind = K_OR;
          3'd6: kind = K_XNOR;
          3'd7: kind = K_HOLD;
          default: kind = K_ILL;
        endcase
      end
      2'd1: begin
        // op_code[2] is a don't-care in this group.
        case (s1_code_q[1:0])
          2'd0: kind = K_NAND;
          2'd1: kind = K_ADD;
          2'd2: kind = K_SUB;
          2'd3: kind = K_HOLD;
          default: kind = K_ILL;
        endcase
      end
      2'd2: begin
        case (s1_code_q[1:0])
          2'd0: kind = K_DEC;
          2'd1: kind = K_INC2;
          2'd2: kind = K_NEG;
          2'd3: kind = K_HOLD;
          default: kind = K_ILL;
        endcase
      end
      default: kind = K_ILL;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  logic signed [W:0] a_ext;
  logic signed [W:0] b_ext;
  logic signed [W:0] one_ext;
  logic signed [W:0] two_ext;
  logic signed [W:0] arith_raw;
  logic [W:0]        arith_out;
  logic [W-1:0]      logic_raw;
  logic              is_arith;
  logic              is_logic;
  logic              is_hold;
  logic              is_ill;
  logic              ovf_raw;
  logic [W:0]        result_new;

  always_comb begin
    // One extra bit of headroom makes every arithmetic op exact.
    a_ext   = {s1_op1_q[W-1], s1_op1_q};
    b_ext   = {s1_op2_q[W-1], s1_op2_q};
    one_ext = {{W{1'b0}}, 1'b1};
    two_ext = {{(W-1){1'b0}}, 2'b10};

    arith_raw = '0;
    logic_raw = '0;
    is_arith  = 1'b0;
    is_logic  = 1'b0;
    is_hold   = 1'b0;
    is_ill    = 1'b0;

    case (kind)
      K_ADD:  begin arith_raw = a_ext + b_ext;   is_arith = 1'b1; end
      K_SUB:  begin arith_raw = a_ext - b_ext;   is_arith = 1'b1; end
      K_DEC:  begin arith_raw = a_ext - one_ext; is_arith = 1'b1; end
      K_INC2: begin arith_raw = b_ext + two_ext; is_arith = 1'b1; end
      K_NEG:  begin arith_raw = -a_ext;          is_arith = 1'b1; end
      K_XOR:  begin logic_raw = s1_op1_q ^ s1_op2_q;    is_logic = 1'b1; end
      K_AND:  begin logic_raw = s1_op1_q & s1_op2_q;    is_logic = 1'b1; end
      K_NAND: begin logic_raw = ~(s1_op1_q & s1_op2_q); is_logic = 1'b1; end
      K_OR:   begin logic_raw = s1_op1_q | s1_op2_q;    is_logic = 1'b1; end
      K_XNOR: begin logic_raw = ~(s1_op1_q ^ s1_op2_q); is_logic = 1'b1; end
      K_HOLD: is_hold = 1'b1;
      default: is_ill = 1'b1;
    endcase

    // Top two bits disagree exactly when the value leaves the W-bit signed range.
    ovf_raw = arith_raw[W] ^ arith_raw[W-1];

`ifdef ALU_PIPE_SATURATE_EN
    if (ovf_raw) begin
      // Sign bit of the exact result picks the rail.
      arith_out = arith_raw[W] ? {2'b11, {(W-1){1'b0}}} : {2'b00, {(W-1){1'b1}}};
    end else begin
      arith_out = arith_raw;
    end
`else
    arith_out = arith_raw;
`endif

    result_new = '0;
    if (is_arith) begin
      result_new = arith_out;
    end else if (is_logic) begin
      result_new = {1'b0, logic_raw};
    end else if (is_hold) begin
      result_new = last_result_q;
    end else begin
      result_new = '0;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op1_d   = s1_op1_q;
    s1_op2_d   = s1_op2_q;
    s1_grp_d   = s1_grp_q;
    s1_code_d  = s1_code_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_op1_d   = operand1;
      s1_op2_d   = operand2;
      s1_grp_d   = op_group;
      s1_code_d  = op_code;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d    = s2_valid_q;
    s2_result_d   = s2_result_q;
    s2_ovf_d      = s2_ovf_q;
    s2_zero_d     = s2_zero_q;
    s2_err_d      = s2_err_q;
    last_result_d = last_result_q;
    if (s2_load) begin
      s2_valid_d  = 1'b1;
      s2_result_d = result_new;
      s2_ovf_d    = is_arith && ovf_raw;
      s2_zero_d   = (result_new == '0);
      s2_err_d    = is_ill;
      if (is_arith || is_logic) begin
        last_result_d = result_new;
      end
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    op_count_d  = op_count_q;
    err_count_d = err_count_q;
    if (out_fire && (op_count_q != {CNT_WIDTH{1'b1}})) begin
      op_count_d = op_count_q + CNT_WIDTH'(1);
    end
    if (out_fire && s2_err_q && (err_count_q != {CNT_WIDTH{1'b1}})) begin
      err_count_d = err_count_q + CNT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_op1_q      <= '0;
      s1_op2_q      <= '0;
      s1_grp_q      <= '0;
      s1_code_q     <= '0;
      s2_valid_q    <= 1'b0;
      s2_result_q   <= '0;
      s2_ovf_q      <= 1'b0;
      s2_zero_q     <= 1'b0;
      s2_err_q      <= 1'b0;
      last_result_q <= '0;
      op_count_q    <= '0;
      err_count_q   <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_op1_q      <= s1_op1_d;
      s1_op2_q      <= s1_op2_d;
      s1_grp_q      <= s1_grp_d;
      s1_code_q     <= s1_code_d;
      s2_valid_q    <= s2_valid_d;
      s2_result_q   <= s2_result_d;
      s2_ovf_q      <= s2_ovf_d;
      s2_zero_q     <= s2_zero_d;
      s2_err_q      <= s2_err_d;
      last_result_q <= last_result_d;
      op_count_q    <= op_count_d;
      err_count_q   <= err_count_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    out_valid  = s2_valid_q;
    alu_result = s2_result_q;
    ovf_flag   = s2_ovf_q;
    zero_flag  = s2_zero_q;
    err_flag   = s2_err_q;
    op_count   = op_count_q;
    err_count  = err_count_q;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (DATA_WIDTH=8, CNT_WIDTH=16).
// Directed vectors, backpressure, random traffic against an integer reference model, reset with beats in flight.
module tb_alu_pipe;

  localparam int W    = 8;
  localparam int CW   = 16;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  typedef struct packed {
    logic [W:0] res;
    logic       ovf;
    logic       zero;
    logic       err;
  } beat_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   g;
    logic [2:0]   c;
    beat_t        e;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  operand1 = '0;
  logic [W-1:0]  operand2 = '0;
  logic [1:0]    op_group = '0;
  logic [2:0]    op_code = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W:0]    alu_result;
  logic          ovf_flag;
  logic          zero_flag;
  logic          err_flag;
  logic [CW-1:0] op_count;
  logic [CW-1:0] err_count;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  beat_t      exp_q[$];
  logic [W:0] m_last = '0;
  int         m_ops = 0;
  int         m_errs = 0;

  always #5 clk = ~clk;

  alu_pipe #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .operand1(operand1), .operand2(operand2),
    .op_group(op_group), .op_code(op_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .ovf_flag(ovf_flag), .zero_flag(zero_flag), .err_flag(err_flag),
    .op_count(op_count), .err_count(err_count)
  );

  // Behavioural model: exact integer arithmetic, range check, optional clamp.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] g, input logic [2:0] c, output beat_t e);
    int sa, sb, v, kind; // kind: 0 arith, 1 logic, 2 hold, 3 illegal
    logic [W-1:0] lv;
    logic [1:0] c2;
    sa = $signed(a);
    sb = $signed(b);
    v = 0; lv = '0; kind = 3;
    c2 = c[1:0];
    if (g == 2'd0) begin
      case (c)
        3'd0: begin v = sa + sb; kind = 0; end
        3'd1: begin v = sa - sb; kind = 0; end
        3'd2: begin lv = a ^ b; kind = 1; end
        3'd3: begin lv = a & b; kind = 1; end
        3'd4: begin lv = ~(a & b); kind = 1; end
        3'd5: begin lv = a | b; kind = 1; end
        3'd6: begin lv = ~(a ^ b); kind = 1; end
        default: kind = 2;
      endcase
    end else if (g == 2'd1) begin
      case (c2)
        2'd0: begin lv = ~(a & b); kind = 1; end
        2'd1: begin v = sa + sb; kind = 0; end
        2'd2: begin v = sa - sb; kind = 0; end
        default: kind = 2;
      endcase
    end else if (g == 2'd2) begin
      case (c2)
        2'd0: begin v = sa - 1; kind = 0; end
        2'd1: begin v = sb + 2; kind = 0; end
        2'd2: begin v = -sa; kind = 0; end
        default: kind = 2;
      endcase
    end
    e = '0;
    if (kind == 0) begin
      e.ovf = (v > MAXV) || (v < MINV);
`ifdef ALU_PIPE_SATURATE_EN
      if (v > MAXV) v = MAXV;
      if (v < MINV) v = MINV;
`endif
      e.res = (W+1)'(v);
      m_last = e.res;
    end else if (kind == 1) begin
      e.res = {1'b0, lv};
      m_last = e.res;
    end else if (kind == 2) begin
      e.res = m_last;
    end else begin
      e.err = 1'b1;
    end
    e.zero = (e.res == '0);
  endtask

  // One clock: entered after a negedge with inputs set; samples, tracks the model, returns after the next negedge.
  task automatic run_cycle(output bit acc, output bit got, output bit rdy, output beat_t obs);
    beat_t e;
    #1;
    rdy = in_ready;
    acc = in_valid && in_ready && !rst;
    got = out_valid && out_ready && !rst;
    obs = '{alu_result, ovf_flag, zero_flag, err_flag};
    if (acc) begin
      model(operand1, operand2, op_group, op_code, e);
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_last = '0; m_ops = 0; m_errs = 0;
    end else if (got && exp_q.size() > 0) begin
      if (m_ops < 65535) m_ops++;
      if (exp_q[0].err && m_errs < 65535) m_errs++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    bit a, g, r; beat_t o;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    run_cycle(a, g, r, o);
    rst = 1'b0;
  endtask

  task automatic set_rand_op(input bit allow_illegal);
    operand1 = W'($urandom);
    operand2 = W'($urandom);
    op_group = allow_illegal ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
    op_code  = 3'($urandom);
  endtask

  task automatic test_reset();
    bit a, g, r; beat_t o;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    run_cycle(a, g, r, o);
    run_cycle(a, g, r, o);
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", r); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (alu_result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", alu_result); end
    checks++; if ({ovf_flag, zero_flag, err_flag} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {ovf_flag, zero_flag, err_flag}); end
    checks++; if (op_count !== '0 || err_count !== '0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", op_count, err_count); end
    rst = 1'b0; in_valid = 1'b0;
    run_cycle(a, g, r, o);
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL reset_in_ready_rise got=%b exp=1", r); end
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] g,
                              input logic [2:0] c, input logic [W:0] res, input logic ovf,
                              input logic zero, input logic err);
    vec_t v;
    v.a = a; v.b = b; v.g = g; v.c = c;
    v.e = '{res, ovf, zero, err};
    return v;
  endfunction

  task automatic test_directed();
    vec_t tv[16];
    bit a, g, r; beat_t o, e;
    int lat;
`ifdef ALU_PIPE_SATURATE_EN
    tv[0]  = mk(8'd100, 8'd100, 2'd0, 3'd0, 9'h07F, 1, 0, 0);
    tv[1]  = mk(8'h80,  8'h00,  2'd2, 3'd0, 9'h180, 1, 0, 0);
    tv[2]  = mk(8'h80,  8'h00,  2'd2, 3'd2, 9'h07F, 1, 0, 0);
    tv[11] = mk(8'h80,  8'h01,  2'd0, 3'd1, 9'h180, 1, 0, 0);
    tv[12] = mk(8'h00,  8'h7E,  2'd2, 3'd5, 9'h07F, 1, 0, 0);
`else
    tv[0]  = mk(8'd100, 8'd100, 2'd0, 3'd0, 9'h0C8, 1, 0, 0);
    tv[1]  = mk(8'h80,  8'h00,  2'd2, 3'd0, 9'h17F, 1, 0, 0);
    tv[2]  = mk(8'h80,  8'h00,  2'd2, 3'd2, 9'h080, 1, 0, 0);
    tv[11] = mk(8'h80,  8'h01,  2'd0, 3'd1, 9'h17F, 1, 0, 0);
    tv[12] = mk(8'h00,  8'h7E,  2'd2, 3'd5, 9'h080, 1, 0, 0);
`endif
    tv[3]  = mk(8'h0F, 8'h0F, 2'd0, 3'd2, 9'h000, 0, 1, 0);
    tv[4]  = mk(8'h55, 8'h66, 2'd1, 3'd3, 9'h000, 0, 1, 0);
    tv[5]  = mk(8'h30, 8'h03, 2'd0, 3'd5, 9'h033, 0, 0, 0);
    tv[6]  = mk(8'h11, 8'h22, 2'd2, 3'd7, 9'h033, 0, 0, 0);
    tv[7]  = mk(8'h12, 8'h34, 2'd3, 3'd5, 9'h000, 0, 1, 1);
    tv[8]  = mk(8'h00, 8'h00, 2'd0, 3'd7, 9'h033, 0, 0, 0);
    tv[9]  = mk(8'h05, 8'hFD, 2'd1, 3'd5, 9'h002, 0, 0, 0);
    tv[10] = mk(8'hF0, 8'hCC, 2'd1, 3'd0, 9'h03F, 0, 0, 0);
    tv[13] = mk(8'hAA, 8'h55, 2'd0, 3'd6, 9'h000, 0, 1, 0);
    tv[14] = mk(8'hF0, 8'h3C, 2'd0, 3'd3, 9'h030, 0, 0, 0);
    tv[15] = mk(8'h7F, 8'h7F, 2'd0, 3'd7, 9'h030, 0, 0, 0);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      operand1 = tv[i].a; operand2 = tv[i].b; op_group = tv[i].g; op_code = tv[i].c;
      in_valid = 1'b1;
      run_cycle(a, g, r, o);
      in_valid = 1'b0;
      checks++; if (!a) begin errors++; $display("FAIL dir%0d_accept got=0 exp=1", i); end
      lat = 0; g = 1'b0;
      while (!g && lat < 6) begin
        run_cycle(a, g, r, o);
        lat++;
      end
      checks++;
      if (!g) begin
        errors++; $display("FAIL dir%0d_timeout no result within %0d cycles", i, lat);
      end else begin
        if (lat != 2) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=2", i, lat); end
        checks++;
        if (o !== tv[i].e) begin
          errors++; $display("FAIL dir%0d_result got res=%h ovf=%b z=%b e=%b exp res=%h ovf=%b z=%b e=%b",
                             i, o.res, o.ovf, o.zero, o.err, tv[i].e.res, tv[i].e.ovf, tv[i].e.zero, tv[i].e.err);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL dir%0d_model queue empty", i);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin errors++; $display("FAIL dir%0d_model got=%h exp=%h", i, o, e); end
        end
      end
    end
    checks++; if (op_count !== 16'd16) begin errors++; $display("FAIL dir_op_count got=%0d exp=16", op_count); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL dir_err_count got=%0d exp=1", err_count); end
  endtask

  task automatic test_back_to_back();
    bit a, g, r; beat_t o, e;
    int sent, delivered, first_cyc, last_cyc;
    do_reset();
    sent = 0; delivered = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 20 && delivered < 4; cyc++) begin
      in_valid = (sent < 4);
      if (sent < 4) set_rand_op(1'b0);
      out_ready = !(cyc >= 2 && cyc <= 4);
      run_cycle(a, g, r, o);
      if (a) sent++;
      if (cyc >= 2 && cyc <= 4) begin
        checks++; if (r !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_c%0d got=%b exp=0", cyc, r); end
      end
      if (g) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        delivered++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_beat got=%h", o);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin errors++; $display("FAIL b2b_beat%0d got=%h exp=%h", delivered, o, e); end
        end
      end
    end
    in_valid = 1'b0;
    checks++; if (delivered != 4) begin errors++; $display("FAIL b2b_delivered got=%0d exp=4", delivered); end
    checks++; if (first_cyc != 5 || last_cyc != 8) begin errors++; $display("FAIL b2b_timing got=%0d..%0d exp=5..8", first_cyc, last_cyc); end
    checks++; if (op_count !== 16'd4) begin errors++; $display("FAIL b2b_op_count got=%0d exp=4", op_count); end
  endtask

  task automatic test_random();
    bit a, g, r; beat_t o, e;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 65);
      set_rand_op(1'b1);
      run_cycle(a, g, r, o);
      if (g) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra_beat c%0d got=%h", cyc, o);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin errors++; $display("FAIL rand_beat c%0d got=%h exp=%h", cyc, o, e); end
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      run_cycle(a, g, r, o);
      if (g) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_drain_extra got=%h", o);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin errors++; $display("FAIL rand_drain_beat got=%h exp=%h", o, e); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_lost got=%0d beats pending exp=0", exp_q.size()); end
    checks++; if (op_count !== CW'(m_ops)) begin errors++; $display("FAIL rand_op_count got=%0d exp=%0d", op_count, m_ops); end
    checks++; if (err_count !== CW'(m_errs)) begin errors++; $display("FAIL rand_err_count got=%0d exp=%0d", err_count, m_errs); end
  endtask

  task automatic test_reset_inflight();
    bit a, g, r; beat_t o;
    int lat;
    do_reset();
    // One delivered illegal beat so both counters are non-zero before the reset.
    operand1 = 8'h01; operand2 = 8'h02; op_group = 2'd3; op_code = 3'd1;
    in_valid = 1'b1; out_ready = 1'b1;
    run_cycle(a, g, r, o);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) run_cycle(a, g, r, o);
    exp_q.delete();
    out_ready = 1'b0;
    operand1 = 8'd5; operand2 = 8'd6; op_group = 2'd0; op_code = 3'd0;
    in_valid = 1'b1;
    run_cycle(a, g, r, o);
    operand1 = 8'h3C; operand2 = 8'h0F; op_code = 3'd5;
    run_cycle(a, g, r, o);
    in_valid = 1'b0;
    checks++; if (op_count !== 16'd1 || err_count !== 16'd1) begin errors++; $display("FAIL pre_rst_counters got=%0d/%0d exp=1/1", op_count, err_count); end
    rst = 1'b1;
    run_cycle(a, g, r, o);
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", r); end
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flush_out_valid got=%b exp=0", out_valid); end
    checks++; if (op_count !== '0 || err_count !== '0) begin errors++; $display("FAIL rst_flush_counters got=%0d/%0d exp=0/0", op_count, err_count); end
    operand1 = 8'h44; operand2 = 8'h55; op_group = 2'd0; op_code = 3'd7;
    in_valid = 1'b1; out_ready = 1'b1;
    run_cycle(a, g, r, o);
    in_valid = 1'b0;
    lat = 0; g = 1'b0;
    while (!g && lat < 6) begin
      run_cycle(a, g, r, o);
      lat++;
    end
    checks++;
    if (!g) begin
      errors++; $display("FAIL rst_hold_timeout no result within %0d cycles", lat);
    end else if (o !== '{9'h000, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rst_hold got res=%h ovf=%b z=%b e=%b exp res=000 ovf=0 z=1 e=0", o.res, o.ovf, o.zero, o.err);
    end
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL rst_hold_op_count got=%0d exp=1", op_count); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
